// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM state encoding, RISC-V load/store
// funct3 size codes and the store byte-enable helper.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Halfwords always land on lane pair {off[1],0}/{off[1],1}, so off[0] is ignored here.
   function automatic logic [3:0] lane_be(input logic [2:0] size, input logic [1:0] off);
      logic [3:0] be;
      be = 4'b0000;
      case (size)
         F3_B, F3_BU: be = 4'b0001 << off;
         F3_H, F3_HU: be = off[1] ? 4'b1100 : 4'b0011;
         F3_W:        be = 4'b1111;
         default:     be = 4'b0000;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/dmem_byte_lane.sv
// Combinational lane steering: store byte-enables and merged word, load extraction/extension.
// Build option DMEM_MISALIGN_ERR_EN turns misaligned H/HU/W accesses into faults instead of aligning them.
module dmem_byte_lane
   import dmem_pkg::*;
(
   input  logic        write_i,
   input  logic [2:0]  size_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] ram_word_i,
   output logic [3:0]  be_o,
   output logic [31:0] store_word_o,
   output logic [31:0] load_data_o,
   output logic        fault_o
);

   logic        size_ok;
   logic        misalign;
   logic [31:0] wdata_rep;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

`ifdef DMEM_MISALIGN_ERR_EN
   assign misalign = (((size_i == F3_H) || (size_i == F3_HU)) && off_i[0]) ||
                     ((size_i == F3_W) && (off_i != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   always_comb begin
      size_ok      = 1'b0;
      wdata_rep    = wdata_i;
      store_word_o = ram_word_i;
      load_data_o  = 32'd0;

      // Stores only accept signed-style codes; loads additionally accept BU/HU.
      if (write_i) begin
         size_ok = (size_i == F3_B) || (size_i == F3_H) || (size_i == F3_W);
      end else begin
         size_ok = (size_i == F3_B) || (size_i == F3_H) || (size_i == F3_W) ||
                   (size_i == F3_BU) || (size_i == F3_HU);
      end
      fault_o = !size_ok || misalign;
      be_o    = fault_o ? 4'b0000 : lane_be(size_i, off_i);

      case (size_i)
         F3_B:    wdata_rep = {4{wdata_i[7:0]}};
         F3_H:    wdata_rep = {2{wdata_i[15:0]}};
         default: wdata_rep = wdata_i;
      endcase
      for (int i = 0; i < 4; i++) begin
         if (be_o[i]) store_word_o[8*i +: 8] = wdata_rep[8*i +: 8];
      end

      byte_sel = ram_word_i[{off_i, 3'b000} +: 8];
      half_sel = off_i[1] ? ram_word_i[31:16] : ram_word_i[15:0];
      case (size_i)
         F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
         F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
         F3_W:    load_data_o = ram_word_i;
         F3_BU:   load_data_o = {24'd0, byte_sel};
         F3_HU:   load_data_o = {16'd0, half_sel};
         default: load_data_o = 32'd0;
      endcase
      if (fault_o) load_data_o = 32'd0;
   end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: IDLE -> WAIT (WAIT_CYCLES) -> RESP, access executed on RESP entry.
// Build option DMEM_MISALIGN_ERR_EN (see dmem_byte_lane) selects fault vs. forced alignment for misaligned accesses.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [2:0]  req_size,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int         AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   dmem_state_t state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        write_q;
   logic [31:0] addr_q;
   logic [2:0]  size_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic        err_q;

   logic [31:0] mem_q [DEPTH_WORDS];

   logic          accept;
   logic          do_access;
   logic          sel_write;
   logic [31:0]   sel_addr;
   logic [2:0]    sel_size;
   logic [31:0]   sel_wdata;
   logic [AW-1:0] sel_idx;
   logic          oob;
   logic [31:0]   ram_word;
   logic [3:0]    be;
   logic [31:0]   store_word;
   logic [31:0]   load_data;
   logic          lane_fault;
   logic          access_err;
   logic          store_en;

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
   assign accept    = req_valid && req_ready;

   // With zero wait states the access runs on the accept edge, before the request is latched.
   assign sel_write = (state_q == IDLE) ? req_write : write_q;
   assign sel_addr  = (state_q == IDLE) ? req_addr  : addr_q;
   assign sel_size  = (state_q == IDLE) ? req_size  : size_q;
   assign sel_wdata = (state_q == IDLE) ? req_wdata : wdata_q;

   assign sel_idx  = sel_addr[2 +: AW];
   assign oob      = {2'b00, sel_addr[31:2]} >= 32'(DEPTH_WORDS);
   assign ram_word = mem_q[sel_idx];

   dmem_byte_lane u_lane (
      .write_i      (sel_write),
      .size_i       (sel_size),
      .off_i        (sel_addr[1:0]),
      .wdata_i      (sel_wdata),
      .ram_word_i   (ram_word),
      .be_o         (be),
      .store_word_o (store_word),
      .load_data_o  (load_data),
      .fault_o      (lane_fault)
   );

   assign access_err = oob || lane_fault;
   assign store_en   = do_access && sel_write && !access_err && (be != 4'b0000);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      do_access = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (WAIT_CYCLES > 0) begin
                  state_d = WAIT;
                  cnt_d   = WAIT_INIT;
               end else begin
                  state_d   = RESP;
                  do_access = 1'b1;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d   = RESP;
               do_access = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         write_q <= 1'b0;
         addr_q  <= 32'd0;
         size_q  <= 3'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            size_q  <= req_size;
            wdata_q <= req_wdata;
         end
         if (do_access) begin
            rdata_q <= (sel_write || access_err) ? 32'd0 : load_data;
            err_q   <= access_err;
         end
      end
   end

   // Array is not reset; a store cut off by reset before RESP entry never reaches it.
   always_ff @(posedge clock) begin
      if (resetn && store_en) mem_q[sel_idx] <= store_word;
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: drivers push expected {err, rdata} into a queue,
// an independent monitor pops and compares on every response handshake.
module tb_dmem_responder;

   localparam int DEPTH_WORDS = 1024;
   localparam int WAIT_CYCLES = 1;

   localparam logic [2:0] SZ_B  = 3'b000;
   localparam logic [2:0] SZ_H  = 3'b001;
   localparam logic [2:0] SZ_W  = 3'b010;
   localparam logic [2:0] SZ_BU = 3'b100;
   localparam logic [2:0] SZ_HU = 3'b101;

   logic        clock = 1'b0;
   logic        resetn;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [2:0]  req_size;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   logic [32:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   dmem_responder #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .WAIT_CYCLES (WAIT_CYCLES)
   ) dut (
      .clock     (clock),
      .resetn    (resetn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_size  (req_size),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: a response is consumed at the edge following a negedge with valid && ready.
   always @(negedge clock) begin
      if (resetn === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
         logic [32:0] exp;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected: got err=%0b rdata=0x%08h, expected no response", rsp_err, rsp_rdata);
         end else begin
            exp = exp_q.pop_front();
            if ({rsp_err, rsp_rdata} !== exp) begin
               errors++;
               $display("FAIL rsp: got err=%0b rdata=0x%08h, expected err=%0b rdata=0x%08h",
                        rsp_err, rsp_rdata, exp[32], exp[31:0]);
            end
         end
      end
   end

   task automatic do_req(input logic w, input logic [31:0] a, input logic [2:0] s,
                         input logic [31:0] d, input logic exp_err, input logic [31:0] exp_d,
                         input bit expect_rsp);
      int n;
      if (expect_rsp) exp_q.push_back({exp_err, exp_d});
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_size  = s;
      req_wdata = d;
      @(negedge clock);
      n = 0;
      while (!req_ready && n < 100) begin
         @(negedge clock);
         n++;
      end
      if (!req_ready) check("req_accept_timeout", 32'(n), 32'd0);
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = 32'd0;
      req_size  = 3'd0;
      req_wdata = 32'd0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clock);
         n++;
      end
      if (exp_q.size() != 0) begin
         check("drain_timeout", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
      @(posedge clock);
      #1;
   endtask

   initial begin
      logic [31:0] exp_word;
      int n;
      resetn    = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = 32'd0;
      req_size  = 3'd0;
      req_wdata = 32'd0;
      rsp_ready = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("reset_req_ready", 32'(req_ready), 32'd1);
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_rsp_rdata", rsp_rdata, 32'd0);
      check("reset_rsp_err", 32'(rsp_err), 32'd0);
      @(posedge clock);
      #1;
      resetn = 1'b1;

      // Word store/load with response latency measured from the accept edge.
      do_req(1'b1, 32'h10, SZ_W, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1);
      drain();
      do_req(1'b0, 32'h10, SZ_W, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1);
      @(negedge clock);
      n = 1;
      check("busy_req_ready", 32'(req_ready), 32'd0);
      while (!rsp_valid && n < 20) begin
         @(negedge clock);
         n++;
      end
      check("rsp_latency", 32'(n), 32'(WAIT_CYCLES + 1));
      drain();

      // Byte and halfword lanes with sign/zero extension.
      do_req(1'b1, 32'h10, SZ_W,  32'h00000000, 1'b0, 32'h0, 1'b1);
      do_req(1'b1, 32'h13, SZ_B,  32'h00000080, 1'b0, 32'h0, 1'b1);
      do_req(1'b0, 32'h13, SZ_B,  32'h0, 1'b0, 32'hFFFFFF80, 1'b1);
      do_req(1'b0, 32'h13, SZ_BU, 32'h0, 1'b0, 32'h00000080, 1'b1);
      do_req(1'b0, 32'h10, SZ_W,  32'h0, 1'b0, 32'h80000000, 1'b1);
      do_req(1'b1, 32'h12, SZ_H,  32'h00001234, 1'b0, 32'h0, 1'b1);
      do_req(1'b0, 32'h12, SZ_HU, 32'h0, 1'b0, 32'h00001234, 1'b1);
      do_req(1'b1, 32'h10, SZ_H,  32'h0000BEEF, 1'b0, 32'h0, 1'b1);
      do_req(1'b0, 32'h10, SZ_H,  32'h0, 1'b0, 32'hFFFFBEEF, 1'b1);
      do_req(1'b0, 32'h10, SZ_HU, 32'h0, 1'b0, 32'h0000BEEF, 1'b1);
      do_req(1'b0, 32'h11, SZ_B,  32'h0, 1'b0, 32'hFFFFFFBE, 1'b1);
      do_req(1'b0, 32'h12, SZ_BU, 32'h0, 1'b0, 32'h00000034, 1'b1);
      do_req(1'b0, 32'h10, SZ_W,  32'h0, 1'b0, 32'h1234BEEF, 1'b1);
      drain();

      // Misaligned accesses: fault or forced alignment depending on build.
`ifdef DMEM_MISALIGN_ERR_EN
      do_req(1'b0, 32'h11, SZ_H, 32'h0, 1'b1, 32'h0, 1'b1);
      do_req(1'b0, 32'h12, SZ_W, 32'h0, 1'b1, 32'h0, 1'b1);
      do_req(1'b1, 32'h13, SZ_H, 32'h00007777, 1'b1, 32'h0, 1'b1);
      exp_word = 32'h1234BEEF;
`else
      do_req(1'b0, 32'h11, SZ_H, 32'h0, 1'b0, 32'hFFFFBEEF, 1'b1);
      do_req(1'b0, 32'h12, SZ_W, 32'h0, 1'b0, 32'h1234BEEF, 1'b1);
      do_req(1'b1, 32'h13, SZ_H, 32'h00007777, 1'b0, 32'h0, 1'b1);
      exp_word = 32'h7777BEEF;
`endif
      do_req(1'b0, 32'h10, SZ_W, 32'h0, 1'b0, exp_word, 1'b1);

      // Illegal store sizes fault and leave memory untouched.
      do_req(1'b1, 32'h10, SZ_BU,  32'h000000FF, 1'b1, 32'h0, 1'b1);
      do_req(1'b1, 32'h10, 3'b111, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b1);
      do_req(1'b0, 32'h10, SZ_W, 32'h0, 1'b0, exp_word, 1'b1);

      // Out-of-range addresses fault, and must not alias onto word 0.
      do_req(1'b1, 32'h0, SZ_W, 32'h11111111, 1'b0, 32'h0, 1'b1);
      do_req(1'b0, 32'(DEPTH_WORDS * 4), SZ_W, 32'h0, 1'b1, 32'h0, 1'b1);
      do_req(1'b1, 32'(DEPTH_WORDS * 4), SZ_W, 32'hCAFEF00D, 1'b1, 32'h0, 1'b1);
      do_req(1'b0, 32'h80000000, SZ_W, 32'h0, 1'b1, 32'h0, 1'b1);
      do_req(1'b0, 32'h0, SZ_W, 32'h0, 1'b0, 32'h11111111, 1'b1);
      drain();

      // Response back-pressure: outputs hold while rsp_ready is low.
      rsp_ready = 1'b0;
      do_req(1'b0, 32'h0, SZ_W, 32'h0, 1'b0, 32'h11111111, 1'b1);
      @(negedge clock);
      n = 0;
      while (!rsp_valid && n < 20) begin
         @(negedge clock);
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
         check("stall_rsp_rdata", rsp_rdata, 32'h11111111);
         check("stall_req_ready", 32'(req_ready), 32'd0);
         @(negedge clock);
      end
      @(posedge clock);
      #1;
      rsp_ready = 1'b1;
      @(posedge clock);
      #1;
      check("release_rsp_valid", 32'(rsp_valid), 32'd0);
      check("release_req_ready", 32'(req_ready), 32'd1);
      drain();

      // Reset during WAIT of a store: the store is discarded.
      do_req(1'b1, 32'h20, SZ_W, 32'hAAAA5555, 1'b0, 32'h0, 1'b1);
      drain();
      do_req(1'b1, 32'h20, SZ_W, 32'h12345678, 1'b0, 32'h0, 1'b0);
      resetn = 1'b0;
      @(posedge clock);
      #1;
      check("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("midreset_req_ready", 32'(req_ready), 32'd1);
      check("midreset_rsp_err", 32'(rsp_err), 32'd0);
      resetn = 1'b1;
      do_req(1'b0, 32'h20, SZ_W, 32'h0, 1'b0, 32'hAAAA5555, 1'b1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got no end, expected $finish");
      $fatal(1, "time limit");
   end

endmodule
